mem_port_arbiter: RTL

- Shares the single unified memory port between instruction fetch (IF) and data memory access (DM) in the multicycle MIPS core.
- Arbitrates between the two requesters and sequences a fixed-latency memory access.
- Drives the select of the 32-bit address mux (0 = IF address, 1 = DM address) and returns read data through per-requester registered outputs.

---
 rtl/mem_port_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the unified memory port between instruction fetch and data access.
// Optional MEMARB_ROUND_ROBIN_EN alternates grants under contention; default is DM-over-IF priority.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_wdata,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        addr_sel,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    state_t           state, state_nx;
    logic             owner;      // 0 = IF, 1 = DM; drives addr_sel directly
    logic             owner_we;   // store flag latched at grant
    logic             grant_dm;
    logic [CNT_W-1:0] cnt;

`ifdef MEMARB_ROUND_ROBIN_EN
    logic last_owner;
    // Under contention the grant goes to whoever did not win last time.
    always_comb grant_dm = dm_req && (!if_req || !last_owner);
`else
    always_comb grant_dm = dm_req;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (if_req || dm_req) state_nx = S_ACCESS;
            S_ACCESS: if (cnt == '0) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            owner    <= 1'b0;
            owner_we <= 1'b0;
            cnt      <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
`ifdef MEMARB_ROUND_ROBIN_EN
            last_owner <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (if_req || dm_req) begin
                    owner    <= grant_dm;
                    owner_we <= grant_dm && dm_we;
                    cnt      <= CNT_INIT;
`ifdef MEMARB_ROUND_ROBIN_EN
                    last_owner <= grant_dm;
`endif
                end
                S_ACCESS: begin
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                    else if (!owner)
                        if_rdata <= mem_rdata;
                    else if (!owner_we)
                        dm_rdata <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Owner only changes on grant, so the address mux is stable through the access.
    assign addr_sel  = owner;
    assign mem_en    = (state == S_ACCESS);
    assign mem_we    = mem_en && owner && owner_we;
    assign mem_wdata = (mem_en && owner) ? dm_wdata : '0;
    assign if_done   = (state == S_DONE) && !owner;
    assign dm_done   = (state == S_DONE) && owner;
    assign busy      = (state != S_IDLE);

endmodule
